// File: rtl/oam_dma.sv
// oam_dma: sprite-attribute DMA engine.
// A CPU write to the DMA register at FF46 starts a transfer of DMA_LEN bytes.
// The source is page_reg:00, and pages E0..FF are folded back into C0..DF.
// The destination is FE00. Each byte takes one READ cycle and one WRITE cycle.
module oam_dma #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DMA_LEN    = 160
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data_in,
  input  logic                  cpu_wr_en,
  input  logic                  cpu_rd_en,
  output logic [DATA_WIDTH-1:0] reg_data_out,
  output logic                  reg_hit,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  dma_active,
  output logic                  dma_done
);

  localparam int IDX_W = (DMA_LEN > 1) ? $clog2(DMA_LEN) : 1;
  localparam logic [ADDR_WIDTH-1:0] REG_ADDR   = ADDR_WIDTH'(16'hFF46);
  localparam logic [ADDR_WIDTH-1:0] DEST_BASE  = ADDR_WIDTH'(16'hFE00);
  localparam logic [DATA_WIDTH-1:0] ECHO_LIMIT = DATA_WIDTH'(8'hE0);
  localparam logic [DATA_WIDTH-1:0] ECHO_MASK  = DATA_WIDTH'(8'hDF);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(DMA_LEN - 1);

  typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  logic [IDX_W-1:0]        r_idx;
  logic [DATA_WIDTH-1:0]   r_pageReg;
  logic [DATA_WIDTH-1:0]   r_dataReg;
  logic                    r_done;

  logic                    w_regWrite;
  logic                    w_regRead;
  logic                    w_lastIdx;
  logic [DATA_WIDTH-1:0]   w_srcPage;
  logic [ADDR_WIDTH-1:0]   w_srcBase;

  assign w_regWrite = cpu_wr_en && (cpu_addr == REG_ADDR);
  assign w_regRead  = cpu_rd_en && (cpu_addr == REG_ADDR);
  assign w_lastIdx  = (r_idx == LAST_IDX);

  // Pages E0..FF would point at echo RAM, so they are mirrored back onto C0..DF
  assign w_srcPage = (r_pageReg < ECHO_LIMIT) ? r_pageReg : (r_pageReg & ECHO_MASK);
  assign w_srcBase = ADDR_WIDTH'({w_srcPage, 8'h00});

  assign reg_data_out = w_regRead ? r_pageReg : '0;
  assign reg_hit      = w_regRead;
  assign dma_done     = r_done;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; a register write from any state restarts the transfer
  always_comb begin
    w_nextState = r_state;
    if (w_regWrite) begin
      w_nextState = START;
    end else begin
      case (r_state)
        IDLE:    w_nextState = IDLE;
        START:   w_nextState = READ;
        READ:    w_nextState = WRITE;
        WRITE:   w_nextState = w_lastIdx ? IDLE : READ;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Page latch, byte index, read-data holding register and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_pageReg <= '0;
      r_dataReg <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_regWrite) begin
        r_pageReg <= cpu_data_in;
        r_idx     <= '0;
      end else if (r_state == WRITE) begin
        if (w_lastIdx) begin
          r_done <= 1'b1;
          r_idx  <= '0;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
      if (r_state == READ) begin
        r_dataReg <= mem_rd_data;
      end
    end
  end

  // Memory bus outputs decoded from the current state only
  always_comb begin
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    dma_active  = 1'b0;
    case (r_state)
      START: begin
        dma_active = 1'b1;
      end
      READ: begin
        dma_active = 1'b1;
        mem_rd_en  = 1'b1;
        mem_addr   = w_srcBase + ADDR_WIDTH'(r_idx);
      end
      WRITE: begin
        dma_active  = 1'b1;
        mem_wr_en   = 1'b1;
        mem_addr    = DEST_BASE + ADDR_WIDTH'(r_idx);
        mem_wr_data = r_dataReg;
      end
      default: begin
      end
    endcase
  end

endmodule
